// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: two write ports, packed read ports and the scoreboard strobes.
interface reg_file_sb_if #(
    parameter int unsigned N  = 5,
    parameter int unsigned M  = 32,
    parameter int unsigned NR = 2
) ();
    logic            we0;
    logic [N-1:0]    wrAddr0;
    logic [M-1:0]    wrData0;
    logic            we1;
    logic [N-1:0]    wrAddr1;
    logic [M-1:0]    wrData1;
    logic [NR*N-1:0] rdAddr;
    logic [NR*M-1:0] rdData;
    logic [NR-1:0]   rdBusy;
    logic            setBusy;
    logic [N-1:0]    busyAddr;
    logic [N:0]      busyCnt;

    modport master (
        output we0, wrAddr0, wrData0, we1, wrAddr1, wrData1, rdAddr, setBusy, busyAddr,
        input  rdData, rdBusy, busyCnt
    );

    modport slave (
        input  we0, wrAddr0, wrData0, we1, wrAddr1, wrData1, rdAddr, setBusy, busyAddr,
        output rdData, rdBusy, busyCnt
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with two write ports, NR combinational read ports and a pending-write
// scoreboard (busy bit per register plus a registered population count).
module reg_file_sb #(
    parameter int unsigned N      = 5,
    parameter int unsigned M      = 32,
    parameter int unsigned NR     = 2,
    parameter int unsigned BYPASS = 1
) (
    input logic          clk,
    input logic          reset,
    reg_file_sb_if.slave bus
);
    localparam int unsigned Depth = 2 ** N;

    logic [M-1:0]    regs_q [Depth];
    logic [Depth-1:0] busy_q, busy_d;
    logic [N:0]      cnt_q, cnt_d;
    logic            wr0_en, wr1_en, set_en;
    logic [N-1:0]    ra;
    logic [NR*M-1:0] rd_data;
    logic [NR-1:0]   rd_busy;

    // Register 0 is hardwired: its writes and busy marks are dropped here.
    assign wr0_en = bus.we0 && (bus.wrAddr0 != '0);
    assign wr1_en = bus.we1 && (bus.wrAddr1 != '0);
    assign set_en = bus.setBusy && (bus.busyAddr != '0);

    // Set is applied last so it wins over a same-cycle clear.
    always_comb begin
        busy_d = busy_q;
        if (wr0_en) busy_d[bus.wrAddr0] = 1'b0;
        if (wr1_en) busy_d[bus.wrAddr1] = 1'b0;
        if (set_en) busy_d[bus.busyAddr] = 1'b1;
        cnt_d = '0;
        for (int k = 0; k < Depth; k++) begin
            cnt_d = cnt_d + {{N{1'b0}}, busy_d[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < Depth; k++) begin
                regs_q[k] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr0_en) regs_q[bus.wrAddr0] <= bus.wrData0;
            if (wr1_en) regs_q[bus.wrAddr1] <= bus.wrData1;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        ra      = '0;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NR; i++) begin
            ra = bus.rdAddr[i*N +: N];
            if (ra != '0) begin
                rd_data[i*M +: M] = regs_q[ra];
                rd_busy[i]        = busy_q[ra];
                // Forwarding: port 1 checked last so it takes priority.
                if (BYPASS != 0) begin
                    if (bus.we0 && (bus.wrAddr0 == ra)) begin
                        rd_data[i*M +: M] = bus.wrData0;
                        rd_busy[i]        = 1'b0;
                    end
                    if (bus.we1 && (bus.wrAddr1 == ra)) begin
                        rd_data[i*M +: M] = bus.wrData1;
                        rd_busy[i]        = 1'b0;
                    end
                end
            end
        end
    end

    assign bus.rdData  = rd_data;
    assign bus.rdBusy  = rd_busy;
    assign bus.busyCnt = cnt_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a vector table for the default (bypass) instance plus
// hand sequences for the non-bypass instance, saturation-free counting and mid-run reset.
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_file_sb_if #(.N(5), .M(32), .NR(2)) bus ();
    reg_file_sb_if #(.N(5), .M(32), .NR(2)) bus_nb ();

    reg_file_sb #(.N(5), .M(32), .NR(2), .BYPASS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    reg_file_sb #(.N(5), .M(32), .NR(2), .BYPASS(0)) dut_nb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nb)
    );

    typedef struct {
        logic        we0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        we1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        sb;
        logic [4:0]  ba;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  rb;
        logic [5:0]  cnt;
    } vec_t;

    localparam int NumVec = 20;
    vec_t vecs [NumVec];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.we0 = 0; bus.wrAddr0 = '0; bus.wrData0 = '0;
        bus.we1 = 0; bus.wrAddr1 = '0; bus.wrData1 = '0;
        bus.setBusy = 0; bus.busyAddr = '0; bus.rdAddr = '0;
        bus_nb.we0 = 0; bus_nb.wrAddr0 = '0; bus_nb.wrData0 = '0;
        bus_nb.we1 = 0; bus_nb.wrAddr1 = '0; bus_nb.wrData1 = '0;
        bus_nb.setBusy = 0; bus_nb.busyAddr = '0; bus_nb.rdAddr = '0;
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // we0 a0 d0 we1 a1 d1 sb ba ra0 ra1 | rd0 rd1 rb cnt(after edge)
        vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 2'b00, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 2'b00, 0};
        vecs[2]  = '{1, 7, 32'h11, 0, 0, 0, 0, 0, 5, 7, 32'hDEADBEEF, 32'h11, 2'b00, 0};
        vecs[3]  = '{1, 9, 32'hAA, 1, 9, 32'hBB, 0, 0, 9, 7, 32'hBB, 32'h11, 2'b00, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 7, 32'hBB, 32'h11, 2'b00, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 1, 3, 3, 4, 0, 0, 2'b00, 1};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 1, 4, 3, 4, 0, 0, 2'b01, 2};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 1, 4, 3, 4, 0, 0, 2'b11, 2};
        vecs[8]  = '{0, 0, 0, 1, 3, 32'h33, 0, 0, 3, 4, 32'h33, 0, 2'b10, 1};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 32'h33, 0, 2'b10, 1};
        vecs[10] = '{1, 4, 32'h44, 0, 0, 0, 1, 4, 4, 3, 32'h44, 32'h33, 2'b00, 1};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 4, 3, 32'h44, 32'h33, 2'b01, 1};
        vecs[12] = '{1, 0, 32'h55, 0, 0, 0, 1, 0, 0, 4, 0, 32'h44, 2'b10, 1};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1};
        vecs[14] = '{1, 6, 32'h66, 0, 0, 0, 0, 0, 6, 4, 32'h66, 32'h44, 2'b10, 1};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 1, 10, 4, 10, 32'h44, 0, 2'b01, 2};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 1, 11, 10, 11, 0, 0, 2'b01, 3};
        vecs[17] = '{1, 10, 32'hA0, 1, 11, 32'hB0, 0, 0, 10, 11, 32'hA0, 32'hB0, 2'b00, 1};
        vecs[18] = '{1, 4, 32'h40, 1, 4, 32'h4F, 0, 0, 4, 10, 32'h4F, 32'hA0, 2'b00, 0};
        vecs[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 4, 11, 32'h4F, 32'hB0, 2'b00, 0};

        idle();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;

        // Reset state on both instances.
        bus.rdAddr = {5'd3, 5'd5};
        bus_nb.rdAddr = {5'd3, 5'd5};
        #1;
        check("reset_rdData", 64'(bus.rdData), 64'h0);
        check("reset_rdBusy", 64'(bus.rdBusy), 64'h0);
        check("reset_busyCnt", 64'(bus.busyCnt), 64'h0);
        check("reset_nb_rdData", 64'(bus_nb.rdData), 64'h0);

        // Non-bypass instance: reads see only the pre-edge state.
        bus_nb.we0 = 1; bus_nb.wrAddr0 = 5'd7; bus_nb.wrData0 = 32'h11;
        bus_nb.rdAddr = {5'd0, 5'd7};
        #1;
        check("nb_no_forward", 64'(bus_nb.rdData[31:0]), 64'h0);
        cycle();
        idle();
        bus_nb.rdAddr = {5'd0, 5'd7};
        bus_nb.setBusy = 1; bus_nb.busyAddr = 5'd7;
        #1;
        check("nb_after_write", 64'(bus_nb.rdData[31:0]), 64'h11);
        cycle();
        idle();
        bus_nb.we0 = 1; bus_nb.wrAddr0 = 5'd7; bus_nb.wrData0 = 32'h22;
        bus_nb.rdAddr = {5'd0, 5'd7};
        #1;
        check("nb_old_data", 64'(bus_nb.rdData[31:0]), 64'h11);
        check("nb_busy_kept", 64'(bus_nb.rdBusy), 64'h1);
        check("nb_cnt_before", 64'(bus_nb.busyCnt), 64'h1);
        cycle();
        idle();
        bus_nb.rdAddr = {5'd0, 5'd7};
        #1;
        check("nb_cnt_after", 64'(bus_nb.busyCnt), 64'h0);
        check("nb_new_data", 64'(bus_nb.rdData[31:0]), 64'h22);

        // Vector table on the bypass instance.
        for (int v = 0; v < NumVec; v++) begin
            bus.we0 = vecs[v].we0; bus.wrAddr0 = vecs[v].a0; bus.wrData0 = vecs[v].d0;
            bus.we1 = vecs[v].we1; bus.wrAddr1 = vecs[v].a1; bus.wrData1 = vecs[v].d1;
            bus.setBusy = vecs[v].sb; bus.busyAddr = vecs[v].ba;
            bus.rdAddr = {vecs[v].ra1, vecs[v].ra0};
            #1;
            check($sformatf("v%0d_rd0", v), 64'(bus.rdData[31:0]), 64'(vecs[v].rd0));
            check($sformatf("v%0d_rd1", v), 64'(bus.rdData[63:32]), 64'(vecs[v].rd1));
            check($sformatf("v%0d_rdBusy", v), 64'(bus.rdBusy), 64'(vecs[v].rb));
            cycle();
            idle();
            check($sformatf("v%0d_busyCnt", v), 64'(bus.busyCnt), 64'(vecs[v].cnt));
        end

        // Fill the scoreboard: 10 marks, a write, then every remaining register.
        for (int a = 1; a <= 10; a++) begin
            bus.setBusy = 1; bus.busyAddr = 5'(a);
            cycle();
        end
        idle();
        check("fill10_busyCnt", 64'(bus.busyCnt), 64'd10);
        bus.we0 = 1; bus.wrAddr0 = 5'd20; bus.wrData0 = 32'h2020;
        cycle();
        idle();
        for (int a = 11; a <= 31; a++) begin
            bus.setBusy = 1; bus.busyAddr = 5'(a);
            cycle();
        end
        idle();
        check("fill31_busyCnt", 64'(bus.busyCnt), 64'd31);
        bus.setBusy = 1; bus.busyAddr = 5'd5;
        cycle();
        idle();
        check("full_reset_busy", 64'(bus.busyCnt), 64'd31);
        bus.rdAddr = {5'd0, 5'd20};
        #1;
        check("pre_reset_rd20", 64'(bus.rdData[31:0]), 64'h2020);

        // Mid-run reset with a write and a busy mark in the same cycle.
        reset = 1'b1;
        bus.we0 = 1; bus.wrAddr0 = 5'd12; bus.wrData0 = 32'h12;
        bus.setBusy = 1; bus.busyAddr = 5'd13;
        cycle();
        reset = 1'b0;
        idle();
        #1;
        check("midreset_busyCnt", 64'(bus.busyCnt), 64'h0);
        for (int a = 0; a < 32; a++) begin
            bus.rdAddr = {5'(31 - a), 5'(a)};
            #1;
            check($sformatf("midreset_rd_a%0d", a), 64'(bus.rdData), 64'h0);
            check($sformatf("midreset_busy_a%0d", a), 64'(bus.rdBusy), 64'h0);
        end
        cycle();
        check("post_reset_cnt", 64'(bus.busyCnt), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
